// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter placing N_CORES load/store requesters
// onto the single-port 16-bit data RAM. One access is in flight at a time.
// The RAM address and data are registered one full cycle before RD/WR rise,
// so the level-triggered RD read always sees a stable address.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   req/we[N_CORES]       per-core request and store flag, held until ack
//   addr/wdata            per-core address/store data, core i at [i*W +: W]
//   ack[N_CORES]          one-cycle completion pulse to the granted core
//   rdata, err            load data / out-of-range flag, valid with ack, else 0
//   mem_addr, mem_din     to RAM ADDBUS / DATAIN
//   mem_wr, mem_rd        to RAM WR / RD (never both high)
//   mem_dout              from RAM DATAOUT, sampled only while mem_rd=1
//   acc_cnt               per-core 16-bit ack counters (DMEM_ARB_CNT_EN only)
//
// Build option: define DMEM_ARB_CNT_EN to add the acc_cnt port and counters.

module dmem_arbiter #(
    parameter int N_CORES   = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CORES-1:0]        req,
    input  logic [N_CORES-1:0]        we,
    input  logic [N_CORES*ADDR_W-1:0] addr,
    input  logic [N_CORES*DATA_W-1:0] wdata,
    output logic [N_CORES-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      err,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_din,
    output logic                      mem_wr,
    output logic                      mem_rd,
    input  logic [DATA_W-1:0]         mem_dout
`ifdef DMEM_ARB_CNT_EN
    ,
    output logic [N_CORES*16-1:0]     acc_cnt
`endif
);

    localparam int IDX_W = $clog2(N_CORES);
    // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   ptr, ptr_n;      // last granted core; also the in-flight owner
    logic [IDX_W-1:0]   gnt;
    logic               found;
    logic               op_we, op_we_n;
    logic               in_range;
    logic [ADDR_W-1:0]  mem_addr_n;
    logic [DATA_W-1:0]  mem_din_n, rdata_n;
    logic [N_CORES-1:0] ack_n;
    logic               err_n, mem_wr_n, mem_rd_n;
    int unsigned        idx;

    logic [ADDR_W-1:0]  addr_a  [N_CORES];
    logic [DATA_W-1:0]  wdata_a [N_CORES];

    for (genvar i = 0; i < N_CORES; i++) begin : g_unpack
        assign addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = wdata[i*DATA_W +: DATA_W];
    end

    assign in_range = ({1'b0, mem_addr} < DEPTH_LIM);

    // Round-robin: first requester searching upward from ptr+1, wrapping.
    always_comb begin
        found = 1'b0;
        gnt   = ptr;
        idx   = 0;
        for (int unsigned off = 1; off <= N_CORES; off++) begin
            idx = (32'(ptr) + off) % N_CORES;
            if (!found && req[IDX_W'(idx)]) begin
                found = 1'b1;
                gnt   = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        op_we_n    = op_we;
        mem_addr_n = mem_addr;
        mem_din_n  = mem_din;
        ack_n      = '0;
        rdata_n    = '0;
        err_n      = 1'b0;
        mem_rd_n   = 1'b0;
        mem_wr_n   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    ptr_n      = gnt;
                    op_we_n    = we[gnt];
                    mem_addr_n = addr_a[gnt];
                    mem_din_n  = wdata_a[gnt];
                    state_n    = SETUP;
                end
            end
            SETUP: begin
                if (in_range) begin
                    mem_rd_n = !op_we;
                    mem_wr_n = op_we;
                    state_n  = ACCESS;
                end else begin
                    // Out-of-range: skip the RAM entirely and answer with err.
                    ack_n[ptr] = 1'b1;
                    err_n      = 1'b1;
                    state_n    = RESP;
                end
            end
            ACCESS: begin
                // rdata register doubles as the load capture register.
                ack_n[ptr] = 1'b1;
                if (!op_we) rdata_n = mem_dout;
                state_n = RESP;
            end
            RESP: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= IDX_W'(N_CORES - 1);
            op_we    <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_wr   <= 1'b0;
            mem_rd   <= 1'b0;
            ack      <= '0;
            rdata    <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            op_we    <= op_we_n;
            mem_addr <= mem_addr_n;
            mem_din  <= mem_din_n;
            mem_wr   <= mem_wr_n;
            mem_rd   <= mem_rd_n;
            ack      <= ack_n;
            rdata    <= rdata_n;
            err      <= err_n;
        end
    end

`ifdef DMEM_ARB_CNT_EN
    logic [15:0] cnt [N_CORES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CORES; i++) cnt[i] <= '0;
        end else if (state == RESP) begin
            cnt[ptr] <= cnt[ptr] + 16'd1;
        end
    end

    for (genvar i = 0; i < N_CORES; i++) begin : g_cnt
        assign acc_cnt[i*16 +: 16] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural RAM.
// The driver pushes the expected response for every request it issues; a
// single monitor process pops and checks whenever an ack appears.

module tb_dmem_arbiter;

    localparam int N     = 2;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 1024;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req, we, ack;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   wdata;
    logic [DW-1:0]     rdata, mem_din, mem_dout;
    logic              err, mem_wr, mem_rd;
    logic [AW-1:0]     mem_addr;
`ifdef DMEM_ARB_CNT_EN
    logic [N*16-1:0]   acc_cnt;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .ack      (ack),
        .rdata    (rdata),
        .err      (err),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_wr   (mem_wr),
        .mem_rd   (mem_rd),
        .mem_dout (mem_dout)
`ifdef DMEM_ARB_CNT_EN
        ,
        .acc_cnt  (acc_cnt)
`endif
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return 16'(i * 3 + 10);
    endfunction

    // Behavioural RAM; 16'hDEAD stands in for the floating bus when RD is low.
    logic [DW-1:0] ram [DEPTH];
    bit            ram_ready = 1'b0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
            ram_ready <= 1'b1;
        end else if (mem_wr) begin
            ram[mem_addr[9:0]] <= mem_din;
        end
    end

    assign mem_dout = mem_rd ? ram[mem_addr[9:0]] : 16'hDEAD;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        err;
        logic [15:0] rdata;
        logic [31:0] issue;
        logic [31:0] lat;     // 0 = latency not checked
    } exp_t;

    exp_t          exp_q [N][$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            tests = 0;
    int            fails = 0;
    bit            end_check = 1'b0;
    bit            end_done  = 1'b0;
    exp_t          pop_e, head_e;
    logic [15:0]   cnt_model [N];

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < N; c++) begin
                exp_q[c].delete();
                cnt_model[c] = '0;
            end
            tests++;
            if ({ack, rdata, err, mem_addr, mem_din, mem_wr, mem_rd} != '0) begin
                fails++;
                $display("FAIL reset_values: ack=%b rdata=%h err=%b addr=%h din=%h wr=%b rd=%b required all 0",
                         ack, rdata, err, mem_addr, mem_din, mem_wr, mem_rd);
            end
        end else begin
            if (ack == '0) begin
                tests++;
                if (rdata != '0 || err != 1'b0) begin
                    fails++;
                    $display("FAIL idle_outputs: rdata=%h err=%b required 0 0", rdata, err);
                end
            end else if ($countones(ack) != 1) begin
                tests++;
                fails++;
                $display("FAIL ack_onehot: ack=%b required one-hot", ack);
            end
            for (int c = 0; c < N; c++) begin
                if (ack[c]) begin
                    tests++;
                    if (exp_q[c].size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_ack core%0d at cycle %0d: got ack required none", c, cyc);
                    end else begin
                        pop_e = exp_q[c].pop_front();
                        if (rdata != pop_e.rdata || err != pop_e.err) begin
                            fails++;
                            $display("FAIL response core%0d: rdata=%h err=%b required rdata=%h err=%b",
                                     c, rdata, err, pop_e.rdata, pop_e.err);
                        end
                        if (pop_e.lat != 0) begin
                            tests++;
                            if (cyc - int'(pop_e.issue) != int'(pop_e.lat)) begin
                                fails++;
                                $display("FAIL latency core%0d: got %0d cycles required %0d",
                                         c, cyc - int'(pop_e.issue), pop_e.lat);
                            end
                        end
                    end
                end
                if (exp_q[c].size() != 0) begin
                    head_e = exp_q[c][0];
                    if (cyc - int'(head_e.issue) > 40) begin
                        tests++;
                        fails++;
                        $display("FAIL timeout core%0d: no ack after 40 cycles, required ack", c);
                        void'(exp_q[c].pop_front());
                    end
                end
            end
            if (mem_rd || mem_wr) begin
                tests++;
                if ((mem_rd && mem_wr) || mem_addr >= AW'(DEPTH)) begin
                    fails++;
                    $display("FAIL bus_protocol: rd=%b wr=%b addr=%h required single strobe in range",
                             mem_rd, mem_wr, mem_addr);
                end
            end
`ifdef DMEM_ARB_CNT_EN
            for (int c = 0; c < N; c++) begin
                tests++;
                if (acc_cnt[c*16 +: 16] != cnt_model[c]) begin
                    fails++;
                    $display("FAIL acc_cnt core%0d: got %0d required %0d", c, acc_cnt[c*16 +: 16], cnt_model[c]);
                end
                if (ack[c]) cnt_model[c] = cnt_model[c] + 16'd1;
            end
`endif
            if (end_check && !end_done) begin
                for (int c = 0; c < N; c++) begin
                    tests++;
                    if (exp_q[c].size() != 0) begin
                        fails++;
                        $display("FAIL leftover core%0d: %0d pending required 0", c, exp_q[c].size());
                    end
                end
                end_done = 1'b1;
            end
        end
    end

    // Reference model: apply the request to ref_mem and queue the expected ack.
    task automatic issue(input int c, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input int lat);
        exp_t e;
        e = '0;
        req[c]             = 1'b1;
        we[c]              = w;
        addr[c*AW +: AW]   = a;
        wdata[c*DW +: DW]  = d;
        e.issue = 32'(cyc);
        e.lat   = 32'(lat);
        if (int'(a) >= DEPTH) begin
            e.err = 1'b1;
        end else if (w) begin
            ref_mem[a[9:0]] = d;
        end else begin
            e.rdata = ref_mem[a[9:0]];
        end
        exp_q[c].push_back(e);
    endtask

    task automatic wait_ack(input int c);
        for (int k = 0; k < 45; k++) begin
            @(negedge clk); #1;
            if (ack[c]) break;
        end
        req[c] = 1'b0;
    endtask

    task automatic gap();
        @(negedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    bit [N-1:0] busy;
    int         age [N];
    int         remaining [N];

    initial begin
        req = '0; we = '0; addr = '0; wdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);

        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        gap();

        // preloaded word 0 reads back as 10
        issue(0, 1'b0, 16'd0, 16'd0, 3);
        wait_ack(0); gap();

        // store then load through core1
        issue(1, 1'b1, 16'h0005, 16'hBEEF, 3);
        wait_ack(1); gap();
        issue(1, 1'b0, 16'h0005, 16'd0, 3);
        wait_ack(1); gap();

        // range edges
        issue(0, 1'b0, 16'd1024, 16'd0, 2);
        wait_ack(0); gap();
        issue(1, 1'b1, 16'hFFFF, 16'h1234, 2);
        wait_ack(1); gap();
        issue(1, 1'b0, 16'd1023, 16'd0, 3);
        wait_ack(1); gap();

        // simultaneous requests from reset; core0 re-requests at once and must wait for core1
        rst_n = 1'b0;
        gap();
        rst_n = 1'b1;
        gap();
        issue(0, 1'b0, 16'd2, 16'd0, 3);
        issue(1, 1'b0, 16'd3, 16'd0, 7);
        for (int k = 0; k < 45; k++) begin
            @(negedge clk); #1;
            if (ack[0]) break;
        end
        issue(0, 1'b1, 16'd4, 16'h4444, 8);
        wait_ack(1);
        wait_ack(0); gap();

        // reset while a load is in its RAM cycle
        issue(0, 1'b0, 16'd6, 16'd0, 3);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        req = '0;
        gap();
        rst_n = 1'b1;
        repeat (4) gap();
        issue(0, 1'b0, 16'd6, 16'd0, 3);
        wait_ack(0); gap();

        // randomized traffic; each core owns addresses congruent to its index mod N
        busy = '0;
        for (int c = 0; c < N; c++) begin
            age[c] = 0;
            remaining[c] = 150;
        end
        for (int t = 0; t < 4000; t++) begin
            if (busy == '0 && remaining[0] == 0 && remaining[1] == 0) break;
            gap();
            for (int c = 0; c < N; c++) begin
                if (busy[c] && (ack[c] || age[c] > 60)) begin
                    busy[c] = 1'b0;
                    req[c]  = 1'b0;
                end
                if (busy[c]) begin
                    age[c]++;
                end else if (remaining[c] > 0 && $urandom_range(0, 3) != 0) begin
                    int unsigned r;
                    logic [15:0] a;
                    r = $urandom_range(0, 9);
                    if (r == 0)      a = 16'(1024 + $urandom_range(0, 64511));
                    else if (r == 1) a = 16'(1022 + c);
                    else             a = 16'($urandom_range(0, 511) * 2 + c);
                    issue(c, 1'($urandom_range(0, 1)), a, 16'($urandom), 0);
                    busy[c] = 1'b1;
                    age[c]  = 0;
                    remaining[c]--;
                end
            end
        end
        req = '0;

        repeat (6) gap();
        end_check = 1'b1;
        repeat (2) gap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
